// File: rtl/temp_pkg.sv
// Shared types and constants for the temperature BCD path (converter and monitor).
package temp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAbs,
    StShift,
    StDone
  } state_e;

  localparam int unsigned BCD_DIGITS = 3;
  localparam int unsigned MAX_MAG    = 999;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/temp_bcd_conv_if.sv
// Sample handshake plus BCD result bundle between the sensor front end and the converter.
interface temp_bcd_conv_if
  import temp_pkg::*;
#(
  parameter int unsigned W = 11
);

  logic [W-1:0] sample;
  logic         sample_valid;
  logic         sample_ready;
  bcd_digit_t   temp_value_ones;
  bcd_digit_t   temp_value_tens;
  bcd_digit_t   temp_value_huns;
  logic         temp_value_sign;
  logic         sat;
  logic         out_valid;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready,
    input  temp_value_ones,
    input  temp_value_tens,
    input  temp_value_huns,
    input  temp_value_sign,
    input  sat,
    input  out_valid
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready,
    output temp_value_ones,
    output temp_value_tens,
    output temp_value_huns,
    output temp_value_sign,
    output sat,
    output out_valid
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 before the next shift.
module bcd_add3
  import temp_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/temp_bcd_conv.sv
// Signed binary to sign-magnitude BCD converter, one magnitude bit per cycle, saturating
// at MAX_MAG.
module temp_bcd_conv
  import temp_pkg::*;
#(
  parameter int unsigned W       = 11,
  parameter int unsigned MAX_MAG = temp_pkg::MAX_MAG
) (
  input  logic           clk,
  input  logic           rst,
  temp_bcd_conv_if.slave bus
);

  localparam int unsigned CntW = $clog2(W);
  localparam int unsigned BcdW = 4 * BCD_DIGITS;

  state_e            state_q, state_d;
  logic [W-1:0]      sample_q, sample_d;
  logic [W-1:0]      mag_q, mag_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              sat_q, sat_d;
  logic [BcdW-1:0]   out_bcd_q, out_bcd_d;
  logic              out_sign_q, out_sign_d;
  logic              out_sat_q, out_sat_d;

  logic [W-1:0]      abs_mag;
  logic              sat_now;
  logic [BcdW-1:0]   bcd_adj;
  logic [BcdW-1:0]   bcd_shift;
  logic [W-1:0]      mag_shift;

  // Unsigned W-bit result so that the most negative sample maps to 2^(W-1) without overflow.
  assign abs_mag = sample_q[W-1] ? (~sample_q + W'(1)) : sample_q;
  assign sat_now = abs_mag > W'(MAX_MAG);

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
    bcd_add3 u_bcd_add3 (
      .digit_i(bcd_q[4*i +: 4]),
      .digit_o(bcd_adj[4*i +: 4])
    );
  end

  assign bcd_shift = {bcd_adj[BcdW-2:0], mag_q[W-1]};
  assign mag_shift = {mag_q[W-2:0], 1'b0};

  always_comb begin
    state_d    = state_q;
    sample_d   = sample_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    sat_d      = sat_q;
    out_bcd_d  = out_bcd_q;
    out_sign_d = out_sign_q;
    out_sat_d  = out_sat_q;
    unique case (state_q)
      StIdle: begin
        if (bus.sample_valid) begin
          sample_d = bus.sample;
          state_d  = StAbs;
        end
      end
      StAbs: begin
        sign_d  = sample_q[W-1] && (abs_mag != '0);
        sat_d   = sat_now;
        mag_d   = sat_now ? W'(MAX_MAG) : abs_mag;
        bcd_d   = '0;
        cnt_d   = CntW'(W - 1);
        state_d = StShift;
      end
      StShift: begin
        bcd_d = bcd_shift;
        mag_d = mag_shift;
        cnt_d = cnt_q - CntW'(1);
        // Final shift: results land on the outputs as the FSM enters DONE.
        if (cnt_q == '0) begin
          out_bcd_d  = bcd_shift;
          out_sign_d = sign_q;
          out_sat_d  = sat_q;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      sample_q   <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      sat_q      <= 1'b0;
      out_bcd_q  <= '0;
      out_sign_q <= 1'b0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sample_q   <= sample_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      sat_q      <= sat_d;
      out_bcd_q  <= out_bcd_d;
      out_sign_q <= out_sign_d;
      out_sat_q  <= out_sat_d;
    end
  end

  assign bus.sample_ready    = (state_q == StIdle);
  assign bus.out_valid       = (state_q == StDone);
  assign bus.temp_value_ones = out_bcd_q[3:0];
  assign bus.temp_value_tens = out_bcd_q[7:4];
  assign bus.temp_value_huns = out_bcd_q[11:8];
  assign bus.temp_value_sign = out_sign_q;
  assign bus.sat             = out_sat_q;

endmodule

// File: tb/tb_temp_bcd_conv.sv
// Scoreboarded bench for temp_bcd_conv: directed cases, back-to-back hold, reset abort,
// random samples and a full sweep of the input range.
module tb_temp_bcd_conv;

  localparam int unsigned W = 11;
  localparam int Lat = W + 1;

  typedef struct {
    int         s;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic       sg;
    logic       st;
    int         acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   nvec;
  int   nerr;
  int   ov_count;
  int   ov_last;
  int   ov_prev;
  exp_t q[$];

  logic [3:0] sh_h, sh_t, sh_o;
  logic       sh_sg, sh_st;

  temp_bcd_conv_if #(.W(W)) bus ();

  temp_bcd_conv #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain decimal arithmetic on the signed value.
  function automatic exp_t model(input int s);
    exp_t e;
    int   mag;
    int   m;
    mag  = (s < 0) ? -s : s;
    e.st = (mag > 999);
    m    = e.st ? 999 : mag;
    e.h  = 4'(m / 100);
    e.t  = 4'((m / 10) % 10);
    e.o  = 4'(m % 10);
    e.sg = (s < 0) && (mag != 0);
    e.s  = s;
    e.acc = 0;
    return e;
  endfunction

  // Monitor: pops one expectation per out_valid strobe; otherwise outputs must hold.
  always @(negedge clk) begin
    if (!rst) begin
      {sh_h, sh_t, sh_o, sh_sg, sh_st} = '0;
    end else if (bus.out_valid) begin
      exp_t e;
      ov_count = ov_count + 1;
      ov_prev  = ov_last;
      ov_last  = cyc;
      nvec = nvec + 1;
      if (q.size() == 0) begin
        nerr = nerr + 1;
        $display("FAIL unexpected_out_valid: got strobe at cycle %0d, required none", cyc);
      end else begin
        e = q.pop_front();
        if (bus.temp_value_huns !== e.h || bus.temp_value_tens !== e.t ||
            bus.temp_value_ones !== e.o || bus.temp_value_sign !== e.sg ||
            bus.sat !== e.st || (cyc - e.acc) != Lat) begin
          nerr = nerr + 1;
          $display("FAIL result s=%0d: got %0d%0d%0d sign=%0b sat=%0b lat=%0d, required %0d%0d%0d sign=%0b sat=%0b lat=%0d",
                   e.s, bus.temp_value_huns, bus.temp_value_tens, bus.temp_value_ones,
                   bus.temp_value_sign, bus.sat, cyc - e.acc, e.h, e.t, e.o, e.sg, e.st, Lat);
        end
      end
      {sh_h, sh_t, sh_o, sh_sg, sh_st} = {bus.temp_value_huns, bus.temp_value_tens,
                                          bus.temp_value_ones, bus.temp_value_sign, bus.sat};
    end else if ({bus.temp_value_huns, bus.temp_value_tens, bus.temp_value_ones,
                  bus.temp_value_sign, bus.sat} !== {sh_h, sh_t, sh_o, sh_sg, sh_st}) begin
      nerr = nerr + 1;
      $display("FAIL hold: outputs changed to %0d%0d%0d/%0b/%0b without out_valid, required %0d%0d%0d/%0b/%0b",
               bus.temp_value_huns, bus.temp_value_tens, bus.temp_value_ones, bus.temp_value_sign,
               bus.sat, sh_h, sh_t, sh_o, sh_sg, sh_st);
      {sh_h, sh_t, sh_o, sh_sg, sh_st} = {bus.temp_value_huns, bus.temp_value_tens,
                                          bus.temp_value_ones, bus.temp_value_sign, bus.sat};
    end
  end

  task automatic check(input string name, input int act, input int req);
    nvec = nvec + 1;
    if (act != req) begin
      nerr = nerr + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.sample_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) check("ready_timeout", 0, 1);
  endtask

  // Offers s until accepted; call between edges. Returns at #1 after the accepting edge.
  task automatic send(input int s, input bit expect_result);
    exp_t e;
    bus.sample       = s[W-1:0];
    bus.sample_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    bus.sample_valid = 1'b0;
    if (expect_result) begin
      e     = model(s);
      e.acc = cyc;
      q.push_back(e);
    end
    check("ready_low_after_accept", int'(bus.sample_ready), 0);
  endtask

  task automatic drain();
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_pending", q.size(), 0);
  endtask

  initial begin
    int ovc;
    exp_t e;
    nvec = 0;
    nerr = 0;
    ov_count = 0;
    ov_last = 0;
    ov_prev = 0;
    rst = 1'b0;
    bus.sample = '0;
    bus.sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_ready", int'(bus.sample_ready), 1);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_outputs", int'({bus.temp_value_huns, bus.temp_value_tens, bus.temp_value_ones,
                                 bus.temp_value_sign, bus.sat}), 0);

    send(0, 1'b1);
    drain();
    send(123, 1'b1);
    send(-45, 1'b1);
    send(1023, 1'b1);
    send(-1024, 1'b1);
    send(999, 1'b1);
    send(1000, 1'b1);
    send(-1000, 1'b1);
    send(-1, 1'b1);
    drain();

    // Valid held high across two conversions; busy-time sample changes must be ignored.
    ovc = ov_count;
    bus.sample       = 11'd7;
    bus.sample_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    e = model(7);
    e.acc = cyc;
    q.push_back(e);
    for (int t = 0; t < 100 && !bus.sample_ready; t++) begin
      bus.sample = W'($urandom);
      @(posedge clk);
      #1;
    end
    bus.sample = 11'd8;
    @(posedge clk);
    #1;
    e = model(8);
    e.acc = cyc;
    q.push_back(e);
    bus.sample = W'($urandom);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.sample_valid = 1'b0;
    drain();
    repeat (20) @(posedge clk);
    #1;
    check("hold_pulse_count", ov_count - ovc, 2);
    check("hold_pulse_spacing", ov_last - ov_prev, W + 3);

    // Reset five cycles into a conversion of 500.
    ovc = ov_count;
    send(500, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_outputs", int'({bus.temp_value_huns, bus.temp_value_tens, bus.temp_value_ones,
                                 bus.temp_value_sign, bus.sat}), 0);
    check("abort_out_valid", int'(bus.out_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", int'(bus.sample_ready), 1);
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_pulse", ov_count - ovc, 0);
    send(-321, 1'b1);
    drain();

    for (int i = 0; i < 300; i++) begin
      int s;
      s = int'($urandom_range(2047, 0)) - 1024;
      repeat ($urandom_range(3, 0)) begin
        @(posedge clk);
        #1;
      end
      send(s, 1'b1);
    end
    drain();

    for (int s = -1024; s <= 1023; s++) send(s, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/temp_bcd_conv.md
# temp_bcd_conv

Sequential signed-binary to sign-magnitude BCD converter that sits directly upstream of `monitor`. It accepts one two's-complement temperature sample per handshake and saturates the magnitude to 999. It converts the sample with a one-bit-per-cycle shift-add-3 (double dabble) datapath. The result is presented on `temp_value_ones/tens/huns/sign`, together with a one-cycle `out_valid` strobe that drives `monitor.en`.

## Interface
- `W`, 11: sample width, two's complement; range −2^(W−1)..2^(W−1)−1.
- `MAX_MAG`, 999: saturation limit for the magnitude; must fit in 3 BCD digits.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `sample`  in  W  signed temperature, two's complement.
- `sample_valid`  in  1  sample offered this cycle.
- `sample_ready`  out  1  converter can accept a sample.
- `temp_value_ones`  out  4  BCD ones digit.
- `temp_value_tens`  out  4  BCD tens digit.
- `temp_value_huns`  out  4  BCD hundreds digit.
- `temp_value_sign`  out  1  1 = negative.
- `sat`  out  1  result was clamped to `MAX_MAG`.
- `out_valid`  out  1  one-cycle strobe: outputs just updated.

## Operation
- States:
  - IDLE: `sample_ready`=1. On `sample_valid`, capture `sample` and go to ABS.
  - ABS: compute the magnitude as |sample| in W bits, zero-extended so that −2^(W−1) is handled. If the magnitude is greater than `MAX_MAG`, load `MAX_MAG` and set the internal sat bit. Load the shift register with BCD = 0, set the bit counter to W−1, and go to SHIFT.
  - SHIFT: once per cycle, apply add-3 to every BCD digit that is ≥5, then shift left one bit from the magnitude into the BCD. When the counter reaches 0, go to DONE.
  - DONE: register the digits, sign and sat onto the outputs, pulse `out_valid`, and return to IDLE.
- Sign rule: `temp_value_sign` = sample[W−1] AND magnitude ≠ 0. Negative zero is therefore impossible.
- A saturated negative sample gives sign=1 and 999.
- Outputs hold their last result between conversions. They change only in the cycle `out_valid` is high.
- `sample_valid` seen while `sample_ready`=0 is ignored. The sample is not queued, and no error is flagged.
- Digits are always legal BCD (0–9). Input to the add-3 stage never exceeds 9 before correction.

## Timing
- Handshake: transfer occurs on the rising edge where `sample_valid` & `sample_ready`. Call this edge E0.
- `sample_ready` falls after E0 and stays low through DONE.
- Sequence: ABS during cycle 1, SHIFT during cycles 2..W+1 (W shifts), DONE during cycle W+2.
- `out_valid`=1 and the new outputs are visible in cycle W+2: 13 cycles after E0 for W=11.
- `sample_ready` returns high in cycle W+3, so the throughput is one sample per W+3 cycles.
- A new sample presented in the same cycle `sample_ready` rises is accepted on that edge.
- Reset values:
  - state = IDLE, `sample_ready`=1 (once rst deasserts).
  - All digits 0, `temp_value_sign`=0, `sat`=0, `out_valid`=0.
- Reset asserted mid-conversion aborts immediately. Outputs return to the reset values, the partial result is discarded, and no `out_valid` is produced.

## Structure
- Shared package `temp_pkg` holds:
  - the state enum {IDLE, ABS, SHIFT, DONE};
  - `BCD_DIGITS`=3 and `MAX_MAG`=999;
  - the BCD digit typedef (4 bits), which `monitor` also uses.
- Sub-module `bcd_add3`: 4-bit combinational correction (≥5 → +3). Instantiate it three times in the SHIFT datapath.
- The FSM, magnitude/saturation logic, bit counter and output registers all live in the top module.

## Test plan
- Reset, then `sample`=0 → 13 cycles later `out_valid`, digits 0/0/0, sign 0, sat 0.
- `sample`=123 → digits huns=1 tens=2 ones=3, sign 0, sat 0. Then `sample`=−45 → 0/4/5, sign 1.
- `sample`=1023 → 9/9/9, sat 1, sign 0. Then `sample`=−1024 → 9/9/9, sat 1, sign 1.
- Hold `sample_valid` high continuously with 7 then 8 → exactly two `out_valid` pulses, spaced 14 cycles apart, giving 007 then 008. Changes to `sample` while busy have no effect.
- Assert rst 5 cycles after accepting 500 → all outputs 0 immediately and no `out_valid`. After release, `sample_ready`=1 and the next sample converts normally.
- Exhaustive sweep of −1024..1023 against a reference model → every result matches, with sign and sat correct and every digit ≤9.
